// File: rtl/pt100_pkg.sv
// Shared constants and types for the PT100 temperature <-> ADC conversion path.
// Both the forward converter and temp_to_adc import this package so the
// scaling stays identical in both directions.
package pt100_pkg;

    localparam int ADC_RES = 10;                 // ADC code width, 1024 = 2^ADC_RES
    localparam int TEMP_W  = 8;                  // temperature width in degC
    localparam int SCALE   = 140;                // full-scale temperature numerator

    localparam int DIV_W   = TEMP_W + ADC_RES;   // dividend / quotient width
    localparam int REM_W   = $clog2(SCALE) + 1;  // holds the pre-subtract remainder
    localparam int CNT_W   = $clog2(DIV_W + 1);  // step counter, counts DIV_W..0

    localparam logic [ADC_RES-1:0] ADC_MAX = '1; // 2^ADC_RES - 1

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_e;

    // temp*2^ADC_RES + (SCALE-1): adding SCALE-1 turns the truncating divide
    // into a ceiling divide.
    function automatic logic [DIV_W-1:0] ceil_dividend(input logic [TEMP_W-1:0] temp);
        return {temp, {ADC_RES{1'b0}}} + DIV_W'(SCALE - 1);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Generic unsigned restoring divider, one quotient bit per step.
// load_i primes the shift register with the dividend; each step_i shifts
// {rem, q} left and conditionally subtracts the divisor. last_step_o is high
// in the cycle whose step produces the final quotient bit.
module seq_divider #(
    parameter int DIV_W = 18,
    parameter int REM_W = 9,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [DIV_W-1:0] dividend_i,
    input  logic [REM_W-1:0] divisor_i,
    output logic [DIV_W-1:0] quotient_o,
    output logic             last_step_o
);

    logic [DIV_W-1:0] q_q,   q_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REM_W:0]   shifted;

    // Next-state logic for one restoring division step.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
        q_d     = q_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        shifted = {rem_q, q_q[DIV_W-1]};
        if (load_i) begin
            q_d   = dividend_i;
            rem_d = '0;
            cnt_d = CNT_W'(DIV_W);
        end else if (step_i && (cnt_q != '0)) begin
            if (shifted >= {1'b0, divisor_i}) begin
                rem_d = REM_W'(shifted - {1'b0, divisor_i});
                q_d   = {q_q[DIV_W-2:0], 1'b1};
            end else begin
                rem_d = REM_W'(shifted);
                q_d   = {q_q[DIV_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Divider state registers, cleared by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            q_q   <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient_o  = q_q;
    assign last_step_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/temp_to_adc.sv
// Inverse of the ADC-to-temperature converter: returns the smallest ADC code
// whose forward conversion floor(adc*SCALE/2^ADC_RES) reaches temp_i, i.e.
// ceil(temp*2^ADC_RES/SCALE), clipped to ADC_MAX with sat_o flagged.
// One conversion takes 20 cycles behind a start/busy/valid handshake.
module temp_to_adc
    import pt100_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [TEMP_W-1:0]  temp_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic [ADC_RES-1:0] adc_o,
    output logic               sat_o
);

    state_e             state_q, state_d;
    logic               busy_q,  busy_d;
    logic               valid_q, valid_d;
    logic [ADC_RES-1:0] adc_q,   adc_d;
    logic               sat_q,   sat_d;

    logic               div_load;
    logic               div_step;
    logic               div_last;
    logic [DIV_W-1:0]   quotient;

    // temp_i is captured only through the divider load, so later changes are ignored.
    seq_divider #(
        .DIV_W (DIV_W),
        .REM_W (REM_W),
        .CNT_W (CNT_W)
    ) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (div_load),
        .step_i      (div_step),
        .dividend_i  (ceil_dividend(temp_i)),
        .divisor_i   (REM_W'(SCALE)),
        .quotient_o  (quotient),
        .last_step_o (div_last)
    );

    // FSM next state, divider control and output register updates.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        adc_d    = adc_q;
        sat_d    = sat_q;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    div_load = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = DIV;
                end
            end
            DIV: begin
                div_step = 1'b1;
                if (div_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (quotient > DIV_W'(ADC_MAX)) begin
                    adc_d = ADC_MAX;
                    sat_d = 1'b1;
                end else begin
                    adc_d = quotient[ADC_RES-1:0];
                    sat_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any conversion in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            adc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            adc_q   <= adc_d;
            sat_q   <= sat_d;
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign adc_o   = adc_q;
    assign sat_o   = sat_q;

endmodule

// File: tb/tb_temp_to_adc.sv
// Self-checking bench for temp_to_adc: expected results are queued when a
// conversion is started and popped when valid_o appears.
module tb_temp_to_adc;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic [7:0] temp  = 8'd0;
    logic       busy;
    logic       valid;
    logic [9:0] adc;
    logic       sat;

    typedef struct packed {
        logic [9:0] adc;
        logic       sat;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [9:0] last_adc;

    temp_to_adc dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .temp_i  (temp),
        .busy_o  (busy),
        .valid_o (valid),
        .adc_o   (adc),
        .sat_o   (sat)
    );

    always #5 clk = ~clk;

    // Reference: ceil(t*1024/140), clipped to 1023.
    function automatic exp_t model(input int t);
        int   q;
        exp_t e;
        q = (t * 1024 + 139) / 140;
        if (q > 1023) e = '{adc: 10'd1023, sat: 1'b1};
        else          e = '{adc: q[9:0],   sat: 1'b0};
        return e;
    endfunction

    // Start one conversion and queue its expected result; temp is scrambled
    // afterwards to show that only the accepting edge matters.
    task automatic start_conv(input logic [7:0] t, input exp_t e);
        @(negedge clk);
        start = 1'b1;
        temp  = t;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        temp  = 8'($urandom);
    endtask

    // Wait (bounded) for valid_o, check latency, busy and the result.
    task automatic wait_result(input string name);
        int   lat;
        exp_t e;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) begin
                lat = i;
                break;
            end
            if (i == 0 || i == 18) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy cyc %0d: got %b expected 1", name, i, busy);
                end
            end
        end
        checks++;
        if (lat != 19) begin
            errors++;
            $display("FAIL %s latency: got %0d expected 19", name, lat);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty expected entry", name);
        end else begin
            e = sb.pop_front();
            if ({adc, sat} !== e) begin
                errors++;
                $display("FAIL %s result: got adc=%0d sat=%b expected adc=%0d sat=%b",
                         name, adc, sat, e.adc, e.sat);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy at valid: got %b expected 0", name, busy);
        end
        last_adc = adc;
    endtask

    task automatic test_reset();
        int bad;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, valid, adc, sat} !== 13'd0) begin
            errors++;
            $display("FAIL reset_async: got busy=%b valid=%b adc=%0d sat=%b expected all 0",
                     busy, valid, adc, sat);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_nominal();
        int   temps[4] = '{0, 25, 100, 139};
        int   adcs[4]  = '{0, 183, 732, 1017};
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e = '{adc: adcs[k][9:0], sat: 1'b0};
            start_conv(temps[k][7:0], e);
            wait_result($sformatf("nominal_t%0d", temps[k]));
        end
    endtask

    task automatic test_saturation();
        start_conv(8'd140, '{adc: 10'd1023, sat: 1'b1});
        wait_result("sat_t140");
        start_conv(8'd255, '{adc: 10'd1023, sat: 1'b1});
        wait_result("sat_t255");
    endtask

    task automatic test_handshake();
        int   pulses;
        int   lat;
        exp_t e;
        pulses = 0;
        lat    = -1;
        start_conv(8'd25, '{adc: 10'd183, sat: 1'b0});
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (i == 5) begin
                start = 1'b1;
                temp  = 8'd100;
            end
            if (i == 6) start = 1'b0;
            if (valid) begin
                pulses++;
                if (pulses == 1) begin
                    lat = i;
                    e   = sb.pop_front();
                    checks++;
                    if ({adc, sat} !== e) begin
                        errors++;
                        $display("FAIL handshake result: got adc=%0d sat=%b expected adc=%0d sat=%b",
                                 adc, sat, e.adc, e.sat);
                    end
                end
            end
        end
        checks++;
        if (pulses != 1 || lat != 19) begin
            errors++;
            $display("FAIL handshake pulses: got %0d at cyc %0d expected 1 at cyc 19", pulses, lat);
        end
    endtask

    task automatic test_back_to_back();
        int   temps[4] = '{10, 60, 139, 200};
        int   idx;
        int   last_i;
        exp_t e;
        idx    = 0;
        last_i = -1;
        @(negedge clk);
        start = 1'b1;
        temp  = temps[0][7:0];
        sb.push_back(model(temps[0]));
        @(posedge clk);
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (valid && idx < 4) begin
                checks++;
                if ((idx == 0 && i != 19) || (idx > 0 && i - last_i != 20)) begin
                    errors++;
                    $display("FAIL b2b spacing %0d: got cyc %0d prev %0d expected gap 20", idx, i, last_i);
                end
                e = sb.pop_front();
                checks++;
                if ({adc, sat} !== e) begin
                    errors++;
                    $display("FAIL b2b result %0d: got adc=%0d sat=%b expected adc=%0d sat=%b",
                             idx, adc, sat, e.adc, e.sat);
                end
                last_i = i;
                idx++;
                if (idx < 4) begin
                    temp = temps[idx][7:0];
                    sb.push_back(model(temps[idx]));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (idx != 4) begin
            errors++;
            $display("FAIL b2b count: got %0d expected 4", idx);
        end
        sb.delete();
    endtask

    task automatic test_abort();
        int pulses;
        @(negedge clk);
        start = 1'b1;
        temp  = 8'd100;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, valid, adc, sat} !== 13'd0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b valid=%b adc=%0d sat=%b expected all 0",
                     busy, valid, adc, sat);
        end
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_no_valid: got %0d pulses expected 0", pulses);
        end
        start_conv(8'd50, '{adc: 10'd366, sat: 1'b0});
        wait_result("abort_restart_t50");
    endtask

    task automatic test_roundtrip();
        int a;
        for (int t = 0; t < 140; t++) begin
            start_conv(t[7:0], model(t));
            wait_result($sformatf("rt_t%0d", t));
            a = int'(last_adc);
            checks++;
            if ((a * 140) / 1024 != t) begin
                errors++;
                $display("FAIL rt_fwd t=%0d: got %0d expected %0d", t, (a * 140) / 1024, t);
            end
            if (t > 0) begin
                checks++;
                if (((a - 1) * 140) / 1024 != t - 1) begin
                    errors++;
                    $display("FAIL rt_min t=%0d: got %0d expected %0d", t, ((a - 1) * 140) / 1024, t - 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_handshake();
        test_back_to_back();
        test_abort();
        test_roundtrip();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
